gige_pcs_shared_clkrst: RTL and testbench



---
 rtl/gige_pcs_shared_clkrst_if.sv | 41 ++++
 rtl/gige_pcs_shared_clkrst.sv | 216 +++++++++++++++++++++
 tb/tb_gige_pcs_shared_clkrst.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/gige_pcs_shared_clkrst_if.sv
// RIU write port plus the per-nibble presence, BTVAL, RIU read-back and ready flags
// exchanged between the shared clock/reset controller and up to three nibbles.
interface gige_pcs_shared_clkrst_if;
    logic [5:0]  riu_addr_out;
    logic [15:0] riu_wr_data_out;
    logic        riu_wr_en_out;
    logic [1:0]  riu_nibble_sel_out;

    logic [15:0] riu_rddata_1, riu_rddata_2, riu_rddata_3;
    logic        riu_valid_1, riu_valid_2, riu_valid_3;
    logic        riu_prsnt_1, riu_prsnt_2, riu_prsnt_3;
    logic [8:0]  rx_btval_1, rx_btval_2, rx_btval_3;
    logic        tx_dly_rdy_1, tx_dly_rdy_2, tx_dly_rdy_3;
    logic        rx_dly_rdy_1, rx_dly_rdy_2, rx_dly_rdy_3;
    logic        tx_vtc_rdy_1, tx_vtc_rdy_2, tx_vtc_rdy_3;
    logic        rx_vtc_rdy_1, rx_vtc_rdy_2, rx_vtc_rdy_3;

    modport master (
        output riu_addr_out, riu_wr_data_out, riu_wr_en_out, riu_nibble_sel_out,
        input  riu_rddata_1, riu_rddata_2, riu_rddata_3,
        input  riu_valid_1, riu_valid_2, riu_valid_3,
        input  riu_prsnt_1, riu_prsnt_2, riu_prsnt_3,
        input  rx_btval_1, rx_btval_2, rx_btval_3,
        input  tx_dly_rdy_1, tx_dly_rdy_2, tx_dly_rdy_3,
        input  rx_dly_rdy_1, rx_dly_rdy_2, rx_dly_rdy_3,
        input  tx_vtc_rdy_1, tx_vtc_rdy_2, tx_vtc_rdy_3,
        input  rx_vtc_rdy_1, rx_vtc_rdy_2, rx_vtc_rdy_3
    );

    modport slave (
        input  riu_addr_out, riu_wr_data_out, riu_wr_en_out, riu_nibble_sel_out,
        output riu_rddata_1, riu_rddata_2, riu_rddata_3,
        output riu_valid_1, riu_valid_2, riu_valid_3,
        output riu_prsnt_1, riu_prsnt_2, riu_prsnt_3,
        output rx_btval_1, rx_btval_2, rx_btval_3,
        output tx_dly_rdy_1, tx_dly_rdy_2, tx_dly_rdy_3,
        output rx_dly_rdy_1, rx_dly_rdy_2, rx_dly_rdy_3,
        output tx_vtc_rdy_1, tx_vtc_rdy_2, tx_vtc_rdy_3,
        output rx_vtc_rdy_1, rx_vtc_rdy_2, rx_vtc_rdy_3
    );
endinterface

// File: rtl/gige_pcs_shared_clkrst.sv
// Shared clock-enable, PLL-lock model and BITSLICE bring-up sequencer for up to three
// native-mode LVDS SGMII nibbles, ending with release of the 125 MHz logic resets.
module gige_pcs_shared_clkrst #(
    parameter int         LOCK_CYCLES = 64,
    parameter int         BSC_HOLD    = 16,
    parameter int         BS_HOLD     = 16,
    parameter logic [5:0] RIU_ADDR    = 6'h0C
) (
    input  logic                      refclk625_in,
    input  logic                      reset,
    gige_pcs_shared_clkrst_if.master  riu,
    output logic clk312_out,
    output logic clk125_out,
    output logic tx_pll_clk_out,
    output logic rx_pll_clk_out,
    output logic tx_rdclk_out,
    output logic riu_clk_out,
    output logic tx_locked,
    output logic rx_locked,
    output logic tx_bsc_rst_out,
    output logic rx_bsc_rst_out,
    output logic tx_bs_rst_out,
    output logic rx_bs_rst_out,
    output logic tx_rst_dly_out,
    output logic rx_rst_dly_out,
    output logic tx_bsc_en_vtc_out,
    output logic rx_bsc_en_vtc_out,
    output logic tx_bs_en_vtc_out,
    output logic rx_bs_en_vtc_out,
    output logic rst_125_out,
    output logic tx_logic_reset,
    output logic rx_logic_reset
);
    localparam logic [2:0] S_PLL  = 3'd0;
    localparam logic [2:0] S_BSC  = 3'd1;
    localparam logic [2:0] S_BS   = 3'd2;
    localparam logic [2:0] S_DLY  = 3'd3;
    localparam logic [2:0] S_RIU  = 3'd4;
    localparam logic [2:0] S_VTC  = 3'd5;
    localparam logic [2:0] S_DONE = 3'd6;
    localparam int         CW     = 16;

    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          clk312_q, clk125_q;
    logic [2:0]    div5_q;
    logic          locked_q, locked_d, bsc_rst_q, bsc_rst_d, bs_rst_q, bs_rst_d;
    logic          en_vtc_q, en_vtc_d, logic_rst_q, logic_rst_d;
    logic          wr_en_q, wr_en_d;
    logic [5:0]    addr_q, addr_d;
    logic [15:0]   data_q, data_d;
    logic [1:0]    sel_q, sel_d;
    logic [2:0]    prsnt_q, tx_dly_q, rx_dly_q, tx_vtc_q, rx_vtc_q;
    logic          dly_ok, vtc_ok, nib_found;
    logic [1:0]    nib_idx;
    logic [8:0]    btval_sel;
    logic          unused_rsvd;

    // Absent nibbles count as ready so a partly populated bank still completes.
    assign dly_ok = &(~prsnt_q | (tx_dly_q & rx_dly_q));
    assign vtc_ok = &(~prsnt_q | (tx_vtc_q & rx_vtc_q));
    assign unused_rsvd = ^{riu.riu_rddata_1, riu.riu_rddata_2, riu.riu_rddata_3,
                           riu.riu_valid_1, riu.riu_valid_2, riu.riu_valid_3};

    // In S_RIU the counter holds the lowest nibble index still eligible for a write.
    always_comb begin
        nib_found = 1'b0;
        nib_idx   = 2'd0;
        for (int n = 2; n >= 0; n--) begin
            if (prsnt_q[n] && (2'(n) >= cnt_q[1:0])) begin
                nib_found = 1'b1;
                nib_idx   = 2'(n);
            end
        end
        case (nib_idx)
            2'd0:    btval_sel = riu.rx_btval_1;
            2'd1:    btval_sel = riu.rx_btval_2;
            default: btval_sel = riu.rx_btval_3;
        endcase
    end

    always_comb begin
        // NOTE: every next-state signal gets a default here, so no branch can infer a latch.
        state_d     = state_q;
        cnt_d       = cnt_q + CW'(1);
        locked_d    = locked_q;
        bsc_rst_d   = bsc_rst_q;
        bs_rst_d    = bs_rst_q;
        en_vtc_d    = en_vtc_q;
        logic_rst_d = logic_rst_q;
        wr_en_d     = 1'b0;
        addr_d      = addr_q;
        data_d      = data_q;
        sel_d       = sel_q;
        case (state_q)
            S_PLL: if (cnt_q == CW'(LOCK_CYCLES - 1)) begin
                state_d  = S_BSC;
                cnt_d    = '0;
                locked_d = 1'b1;
            end
            S_BSC: if (cnt_q == CW'(BSC_HOLD - 1)) begin
                state_d   = S_BS;
                cnt_d     = '0;
                bsc_rst_d = 1'b0;
            end
            S_BS: if (cnt_q == CW'(BS_HOLD - 1)) begin
                state_d  = S_DLY;
                cnt_d    = '0;
                bs_rst_d = 1'b0;
            end
            S_DLY: begin
                cnt_d = '0;
                if (dly_ok) state_d = S_RIU;
            end
            S_RIU: begin
                cnt_d = cnt_q;
                if (wr_en_q) begin
                    wr_en_d = 1'b0;
                end else if (nib_found) begin
                    wr_en_d = 1'b1;
                    addr_d  = RIU_ADDR;
                    data_d  = {7'b0, btval_sel};
                    sel_d   = nib_idx + 2'd1;
                    cnt_d   = CW'(nib_idx) + CW'(1);
                end else begin
                    state_d  = S_VTC;
                    cnt_d    = '0;
                    en_vtc_d = 1'b1;
                end
            end
            S_VTC: begin
                cnt_d = '0;
                if (vtc_ok) begin
                    state_d     = S_DONE;
                    logic_rst_d = 1'b0;
                end
            end
            S_DONE:  cnt_d = '0;
            default: begin
                state_d = S_PLL;
                cnt_d   = '0;
            end
        endcase
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge refclk625_in) begin
        if (!reset) begin
            state_q     <= S_PLL;
            cnt_q       <= '0;
            clk312_q    <= 1'b0;
            clk125_q    <= 1'b0;
            div5_q      <= 3'd0;
            locked_q    <= 1'b0;
            bsc_rst_q   <= 1'b1;
            bs_rst_q    <= 1'b1;
            en_vtc_q    <= 1'b0;
            logic_rst_q <= 1'b1;
            wr_en_q     <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            sel_q       <= '0;
            prsnt_q     <= '0;
            tx_dly_q    <= '0;
            rx_dly_q    <= '0;
            tx_vtc_q    <= '0;
            rx_vtc_q    <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            clk312_q    <= ~clk312_q;
            div5_q      <= (div5_q == 3'd4) ? 3'd0 : div5_q + 3'd1;
            clk125_q    <= (div5_q < 3'd2);
            locked_q    <= locked_d;
            bsc_rst_q   <= bsc_rst_d;
            bs_rst_q    <= bs_rst_d;
            en_vtc_q    <= en_vtc_d;
            logic_rst_q <= logic_rst_d;
            wr_en_q     <= wr_en_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            sel_q       <= sel_d;
            prsnt_q     <= {riu.riu_prsnt_3, riu.riu_prsnt_2, riu.riu_prsnt_1};
            tx_dly_q    <= {riu.tx_dly_rdy_3, riu.tx_dly_rdy_2, riu.tx_dly_rdy_1};
            rx_dly_q    <= {riu.rx_dly_rdy_3, riu.rx_dly_rdy_2, riu.rx_dly_rdy_1};
            tx_vtc_q    <= {riu.tx_vtc_rdy_3, riu.tx_vtc_rdy_2, riu.tx_vtc_rdy_1};
            rx_vtc_q    <= {riu.rx_vtc_rdy_3, riu.rx_vtc_rdy_2, riu.rx_vtc_rdy_1};
        end
    end

    assign clk312_out             = clk312_q;
    assign tx_rdclk_out           = clk312_q;
    assign clk125_out             = clk125_q;
    assign riu_clk_out            = clk125_q;
    assign tx_pll_clk_out         = refclk625_in;
    assign rx_pll_clk_out         = refclk625_in;
    assign tx_locked              = locked_q;
    assign rx_locked              = locked_q;
    assign tx_bsc_rst_out         = bsc_rst_q;
    assign rx_bsc_rst_out         = bsc_rst_q;
    assign tx_bs_rst_out          = bs_rst_q;
    assign rx_bs_rst_out          = bs_rst_q;
    assign tx_rst_dly_out         = bs_rst_q;
    assign rx_rst_dly_out         = bs_rst_q;
    assign tx_bsc_en_vtc_out      = en_vtc_q;
    assign rx_bsc_en_vtc_out      = en_vtc_q;
    assign tx_bs_en_vtc_out       = en_vtc_q;
    assign rx_bs_en_vtc_out       = en_vtc_q;
    assign rst_125_out            = logic_rst_q;
    assign tx_logic_reset         = logic_rst_q;
    assign rx_logic_reset         = logic_rst_q;
    assign riu.riu_wr_en_out      = wr_en_q;
    assign riu.riu_addr_out       = addr_q;
    assign riu.riu_wr_data_out    = data_q;
    assign riu.riu_nibble_sel_out = sel_q;
endmodule

// File: tb/tb_gige_pcs_shared_clkrst.sv
// Self-checking bench: each scenario's expected output timeline is derived from the
// bring-up rules (lock, hold times, write slots, ready sampling) with plain arithmetic.
module tb_gige_pcs_shared_clkrst;
    localparam int L_EDGE = 64;       // lock visible after this many edges past release
    localparam int B_EDGE = 64 + 16;  // BITSLICE_CONTROL reset drop
    localparam int S_EDGE = 80 + 16;  // BITSLICE / delay reset drop

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic clk312_out, clk125_out, tx_pll_clk_out, rx_pll_clk_out, tx_rdclk_out, riu_clk_out;
    logic tx_locked, rx_locked, tx_bsc_rst_out, rx_bsc_rst_out, tx_bs_rst_out, rx_bs_rst_out;
    logic tx_rst_dly_out, rx_rst_dly_out, tx_bsc_en_vtc_out, rx_bsc_en_vtc_out;
    logic tx_bs_en_vtc_out, rx_bs_en_vtc_out, rst_125_out, tx_logic_reset, rx_logic_reset;

    gige_pcs_shared_clkrst_if riu ();

    gige_pcs_shared_clkrst dut (
        .refclk625_in      (clk),
        .reset             (rst_n),
        .riu               (riu.master),
        .clk312_out        (clk312_out),
        .clk125_out        (clk125_out),
        .tx_pll_clk_out    (tx_pll_clk_out),
        .rx_pll_clk_out    (rx_pll_clk_out),
        .tx_rdclk_out      (tx_rdclk_out),
        .riu_clk_out       (riu_clk_out),
        .tx_locked         (tx_locked),
        .rx_locked         (rx_locked),
        .tx_bsc_rst_out    (tx_bsc_rst_out),
        .rx_bsc_rst_out    (rx_bsc_rst_out),
        .tx_bs_rst_out     (tx_bs_rst_out),
        .rx_bs_rst_out     (rx_bs_rst_out),
        .tx_rst_dly_out    (tx_rst_dly_out),
        .rx_rst_dly_out    (rx_rst_dly_out),
        .tx_bsc_en_vtc_out (tx_bsc_en_vtc_out),
        .rx_bsc_en_vtc_out (rx_bsc_en_vtc_out),
        .tx_bs_en_vtc_out  (tx_bs_en_vtc_out),
        .rx_bs_en_vtc_out  (rx_bs_en_vtc_out),
        .rst_125_out       (rst_125_out),
        .tx_logic_reset    (tx_logic_reset),
        .rx_logic_reset    (rx_logic_reset)
    );

    logic [14:0] stat;
    logic [5:0]  clks;
    assign stat = {tx_locked, rx_locked, tx_bsc_rst_out, rx_bsc_rst_out, tx_bs_rst_out,
                   rx_bs_rst_out, tx_rst_dly_out, rx_rst_dly_out, tx_bsc_en_vtc_out,
                   rx_bsc_en_vtc_out, tx_bs_en_vtc_out, rx_bs_en_vtc_out, rst_125_out,
                   tx_logic_reset, rx_logic_reset};
    assign clks = {clk312_out, tx_rdclk_out, clk125_out, riu_clk_out, tx_pll_clk_out,
                   rx_pll_clk_out};

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [14:0] exp_stat(input logic lk, input logic bsc, input logic bs,
                                             input logic vtc, input logic lrst);
        return {{2{lk}}, {2{bsc}}, {4{bs}}, {4{vtc}}, {3{lrst}}};
    endfunction

    task automatic check_reset(input string name);
        check({name, " reset status"}, 32'(stat), 32'(exp_stat(1'b0, 1'b1, 1'b1, 1'b0, 1'b1)));
        check({name, " reset clocks"}, 32'(clks), 32'd0);
        check({name, " reset wr_en"}, 32'(riu.riu_wr_en_out), 32'd0);
        check({name, " reset addr"}, 32'(riu.riu_addr_out), 32'd0);
        check({name, " reset data"}, 32'(riu.riu_wr_data_out), 32'd0);
        check({name, " reset sel"}, 32'(riu.riu_nibble_sel_out), 32'd0);
    endtask

    // Drives one bring-up from reset and compares every cycle against the timeline.
    // abort_at > 0 stops after that edge (the caller then pulses reset).
    task automatic run_scenario(input string name, input logic [2:0] prs, input logic [8:0] b1,
                                input logic [8:0] b2, input logic [8:0] b3, input int rst_cycles,
                                input int vtc_hold, input int abort_at);
        logic [8:0] bt [3];
        int wr_edge [3];
        int wr_nib [3];
        int n, r, v, h, d, last;
        logic hold_en, exp_wr;
        logic [1:0] exp_sel;
        logic [15:0] exp_data;
        bt[0] = b1; bt[1] = b2; bt[2] = b3;
        hold_en = (vtc_hold > 0) && prs[2];

        rst_n = 1'b0;
        riu.riu_prsnt_1 = prs[0]; riu.riu_prsnt_2 = prs[1]; riu.riu_prsnt_3 = prs[2];
        riu.rx_btval_1 = b1; riu.rx_btval_2 = b2; riu.rx_btval_3 = b3;
        riu.tx_dly_rdy_1 = prs[0]; riu.tx_dly_rdy_2 = prs[1]; riu.tx_dly_rdy_3 = prs[2];
        riu.rx_dly_rdy_1 = prs[0]; riu.rx_dly_rdy_2 = prs[1]; riu.rx_dly_rdy_3 = prs[2];
        riu.tx_vtc_rdy_1 = prs[0]; riu.tx_vtc_rdy_2 = prs[1]; riu.tx_vtc_rdy_3 = prs[2];
        riu.rx_vtc_rdy_1 = prs[0]; riu.rx_vtc_rdy_2 = prs[1];
        riu.rx_vtc_rdy_3 = prs[2] && !hold_en;
        riu.riu_rddata_1 = 16'($urandom); riu.riu_rddata_2 = 16'($urandom);
        riu.riu_rddata_3 = 16'($urandom);
        riu.riu_valid_1 = 1'($urandom); riu.riu_valid_2 = 1'($urandom);
        riu.riu_valid_3 = 1'($urandom);

        repeat (rst_cycles) @(posedge clk);
        @(negedge clk);
        check_reset(name);

        // Timeline model: write slots every other edge for present nibbles in order.
        r = S_EDGE + 1;
        n = 0;
        for (int i = 0; i < 3; i++) begin
            if (prs[i]) begin
                wr_edge[n] = r + 1 + 2 * n;
                wr_nib[n]  = i;
                n++;
            end
        end
        v = r + 1 + 2 * n;
        h = hold_en ? v + vtc_hold : 0;
        d = hold_en ? h + 2 : v + 1;
        last = (abort_at > 0) ? abort_at : d + 4;

        rst_n = 1'b1;
        for (int k = 1; k <= last; k++) begin
            @(negedge clk);
            check($sformatf("%s k=%0d clocks", name, k), 32'(clks),
                  32'({{2{k % 2 == 1}}, {2{((k - 1) % 5) < 2}}, 2'b00}));
            check($sformatf("%s k=%0d status", name, k), 32'(stat),
                  32'(exp_stat(k >= L_EDGE, k < B_EDGE, k < S_EDGE, k >= v, k < d)));
            exp_wr = 1'b0; exp_sel = 2'd0; exp_data = 16'd0;
            for (int j = 0; j < n; j++) begin
                if (wr_edge[j] == k) begin
                    exp_wr   = 1'b1;
                    exp_sel  = 2'(wr_nib[j] + 1);
                    exp_data = {7'b0, bt[wr_nib[j]]};
                end
            end
            check($sformatf("%s k=%0d wr_en", name, k), 32'(riu.riu_wr_en_out), 32'(exp_wr));
            if (exp_wr) begin
                check($sformatf("%s k=%0d addr", name, k), 32'(riu.riu_addr_out), 32'h0C);
                check($sformatf("%s k=%0d data", name, k), 32'(riu.riu_wr_data_out), 32'(exp_data));
                check($sformatf("%s k=%0d sel", name, k), 32'(riu.riu_nibble_sel_out), 32'(exp_sel));
            end
            if (hold_en && k == h) riu.rx_vtc_rdy_3 = 1'b1;
        end
    endtask

    initial begin
        logic [2:0] prs;
        // Long reset, all nibbles present, directed BTVALs.
        run_scenario("full", 3'b111, 9'h05A, 9'h1FF, 9'h000, 20, 0, 0);

        // Clock passthrough follows the reference on its high phase.
        @(posedge clk); #1;
        check("pll passthrough", 32'({tx_pll_clk_out, rx_pll_clk_out}), 32'b11);

        // Nibble 2 absent with its delay-ready low: only nibbles 1 and 3 written.
        run_scenario("skip2", 3'b101, 9'($urandom), 9'($urandom), 9'($urandom), 3, 0, 0);

        // Nibble 3 rx VTC ready held low for a while after entering VTC.
        run_scenario("vtc_hold", 3'b111, 9'($urandom), 9'($urandom), 9'($urandom), 3, 6, 0);

        // Reset pulse during the RIU pass, then a full resequence from a one-edge reset.
        run_scenario("abort", 3'b111, 9'($urandom), 9'($urandom), 9'($urandom), 3, 0,
                     S_EDGE + 3);
        run_scenario("reseq", 3'b111, 9'($urandom), 9'($urandom), 9'($urandom), 1, 0, 0);

        // No nibbles present: no writes, DLY and VTC each pass in one cycle.
        run_scenario("none", 3'b000, 9'($urandom), 9'($urandom), 9'($urandom), 2, 0, 0);

        for (int i = 0; i < 3; i++) begin
            prs = 3'($urandom_range(0, 7));
            run_scenario($sformatf("rand%0d", i), prs, 9'($urandom), 9'($urandom),
                         9'($urandom), 2, $urandom_range(0, 8), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
